// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcode/funct constants, reset PC,
// instruction-fetch FSM states and next-PC source selection.
package mips_pkg;

    localparam logic [31:0] PC_RESET_VAL = 32'h0000_3000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_sel_e;

endpackage

// File: rtl/npc_calc.sv
// Next-PC selection for the held instruction: jr > jump > taken beq > sequential,
// plus a flag for a target that is not word-aligned.
module npc_calc
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_plus4_i,
    input  logic [25:0]       instr_idx_i,
    input  logic              br_taken_i,
    input  logic              jump_i,
    input  logic              jr_i,
    input  logic [ADDR_W-1:0] jr_target_i,
    output logic [ADDR_W-1:0] npc_o,
    output logic              misaligned_o
);

    npc_sel_e          sel;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] j_target;

    // Branch offset is the sign-extended word offset, relative to pc+4.
    assign br_target = pc_plus4_i + {{(ADDR_W-18){instr_idx_i[15]}}, instr_idx_i[15:0], 2'b00};
    assign j_target  = {pc_plus4_i[ADDR_W-1:28], instr_idx_i, 2'b00};

    // NOTE: every signal driven from always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        sel = NPC_SEQ;
        if (jr_i)            sel = NPC_JR;
        else if (jump_i)     sel = NPC_J;
        else if (br_taken_i) sel = NPC_BR;
    end

    always_comb begin
        npc_o = pc_plus4_i;
        unique case (sel)
            NPC_JR:  npc_o = jr_target_i;
            NPC_J:   npc_o = j_target;
            NPC_BR:  npc_o = br_target;
            default: npc_o = pc_plus4_i;
        endcase
    end

    assign misaligned_o = |npc_o[1:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, runs one memory fetch at a time and holds the
// fetched word for decode until it retires, then follows the decoder's redirect.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] PC_RESET = PC_RESET_VAL
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              br_taken,
    input  logic              jump,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_target,
    output logic              fetch_err
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              live_q;
    logic [ADDR_W-1:0] npc;
    logic              npc_misaligned;
    logic              retire;

    assign retire   = instr_valid & instr_ready;
    assign pc_plus4 = pc_q + ADDR_W'(4);

    npc_calc #(.ADDR_W(ADDR_W)) u_npc_calc (
        .pc_plus4_i   (pc_plus4),
        .instr_idx_i  (instr_q[25:0]),
        .br_taken_i   (br_taken),
        .jump_i       (jump),
        .jr_i         (jr),
        .jr_target_i  (jr_target),
        .npc_o        (npc),
        .misaligned_o (npc_misaligned)
    );

    // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_REQ;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ:   if (imem_req && imem_ready) state_d = S_WAIT;
            S_WAIT:  if (imem_rvalid)            state_d = S_HOLD;
            S_HOLD:  if (instr_ready)            state_d = npc_misaligned ? S_ERR : S_REQ;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_REQ;
        endcase
    end

    // live_q keeps the request low for the first cycle after reset is released.
    always_comb begin
        imem_req    = (state_q == S_REQ) && live_q;
        instr_valid = (state_q == S_HOLD);
        fetch_err   = (state_q == S_ERR);
    end

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        if (state_q == S_WAIT && imem_rvalid) instr_d = imem_rdata;
        if (retire && !npc_misaligned)        pc_d    = npc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= PC_RESET;
            instr_q <= '0;
            live_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            live_q  <= 1'b1;
        end
    end

    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign pc_out    = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory responder with variable latency
// and stalls, decoder-side driver, and an arithmetic next-PC reference model.
module tb_instr_fetch_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready  = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        br_taken  = 1'b0;
    logic        jump      = 1'b0;
    logic        jr        = 1'b0;
    logic [31:0] jr_target = '0;
    logic        fetch_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] m_pc;

    int          lat        = 1;
    int          stall_cnt  = 0;
    bit          rand_stall = 1'b0;
    int          rsp_cnt    = 0;
    logic [31:0] pend_addr  = '0;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
        .br_taken    (br_taken),
        .jump        (jump),
        .jr          (jr),
        .jr_target   (jr_target),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    // Reference next PC from the architectural rules, in plain arithmetic.
    function automatic logic [31:0] model_npc(input logic [31:0] iw, input logic [31:0] pc,
                                              input bit b, input bit j, input bit r,
                                              input logic [31:0] tgt);
        logic [31:0]        link;
        logic signed [15:0] imm;
        int                 off;
        link = pc + 32'd4;
        imm  = iw[15:0];
        off  = int'(imm) * 4;
        if (r) return tgt;
        if (j) return (link & 32'hF000_0000) | ({6'b0, iw[25:0]} << 2);
        if (b) return link + 32'(off);
        return link;
    endfunction

    // Memory responder: decides its inputs just after each falling edge.
    always @(negedge clk) begin
        #1;
        imem_rvalid = 1'b0;
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
            end
        end
        if (stall_cnt > 0) begin
            imem_ready = 1'b0;
            stall_cnt--;
        end else if (rand_stall) begin
            imem_ready = ($urandom_range(0, 2) != 0);
        end else begin
            imem_ready = 1'b1;
        end
        if (imem_req && imem_ready) begin
            rsp_cnt   = lat;
            pend_addr = imem_addr;
        end
    end

    task automatic check_next_fetch(input string name);
        for (int i = 0; i < 100 && imem_req !== 1'b1; i++) @(negedge clk);
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
            miscompares++;
            $display("FAIL %s: req=%b addr=%h, required req=1 addr=%h", name, imem_req, imem_addr, m_pc);
        end
    endtask

    task automatic retire(input string name, input bit b, input bit j, input bit r,
                          input logic [31:0] tgt, input int hold);
        logic [31:0] exp_instr;
        for (int i = 0; i < 100 && instr_valid !== 1'b1; i++) @(negedge clk);
        vectors++;
        if (instr_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_timeout: instr_valid=%b, required 1 within 100 cycles", name, instr_valid);
            return;
        end
        exp_instr = mem_word(m_pc);
        vectors++;
        if (instr !== exp_instr || pc_out !== m_pc || pc_plus4 !== m_pc + 32'd4) begin
            miscompares++;
            $display("FAIL %s_held: instr=%h pc=%h pc4=%h, required %h %h %h",
                     name, instr, pc_out, pc_plus4, exp_instr, m_pc, m_pc + 32'd4);
        end
        for (int i = 0; i < hold; i++) begin
            jr_target = $urandom;
            br_taken  = 1'($urandom);
            @(negedge clk);
            vectors++;
            if (instr_valid !== 1'b1 || instr !== exp_instr || pc_out !== m_pc) begin
                miscompares++;
                $display("FAIL %s_stall: valid=%b instr=%h pc=%h, required 1 %h %h",
                         name, instr_valid, instr, pc_out, exp_instr, m_pc);
            end
        end
        instr_ready = 1'b1;
        br_taken    = b;
        jump        = j;
        jr          = r;
        jr_target   = tgt;
        m_pc        = model_npc(exp_instr, m_pc, b, j, r, tgt);
        @(negedge clk);
        instr_ready = 1'b0;
        br_taken    = 1'b0;
        jump        = 1'b0;
        jr          = 1'b0;
        jr_target   = $urandom;
    endtask

    task automatic check_reset_outputs(input string name);
        vectors++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 ||
            pc_out !== 32'h0000_3000 || fetch_err !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: req=%b valid=%b instr=%h pc=%h err=%b, required 0 0 0 00003000 0",
                     name, imem_req, instr_valid, instr, pc_out, fetch_err);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_state");
        m_pc  = 32'h0000_3000;
        rst_n = 1'b1;
    endtask

    task automatic test_sequential;
        int vidx[$];
        int req_k = 0;
        instr_ready = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) begin
                vectors++;
                if (imem_req !== 1'b1) begin
                    miscompares++;
                    $display("FAIL first_req: req=%b, required 1 one cycle after reset release", imem_req);
                end
            end
            if (imem_req === 1'b1) begin
                vectors++;
                if (imem_addr !== 32'h0000_3000 + 32'(4 * req_k)) begin
                    miscompares++;
                    $display("FAIL seq_addr: addr=%h, required %h", imem_addr, 32'h0000_3000 + 32'(4 * req_k));
                end
                req_k++;
            end
            if (instr_valid === 1'b1) begin
                vidx.push_back(i);
                vectors++;
                if (pc_out !== m_pc || instr !== mem_word(m_pc)) begin
                    miscompares++;
                    $display("FAIL seq_instr: pc=%h instr=%h, required %h %h", pc_out, instr, m_pc, mem_word(m_pc));
                end
                m_pc = m_pc + 32'd4;
            end
        end
        @(negedge clk);
        instr_ready = 1'b0;
        vectors++;
        if (vidx.size() != 4) begin
            miscompares++;
            $display("FAIL seq_count: %0d instructions in 12 cycles, required 4", vidx.size());
        end else begin
            for (int k = 1; k < 4; k++) begin
                vectors++;
                if (vidx[k] - vidx[k-1] != 3) begin
                    miscompares++;
                    $display("FAIL seq_cadence: gap %0d cycles, required 3", vidx[k] - vidx[k-1]);
                end
            end
        end
    endtask

    task automatic test_branch;
        retire("beq", 1'b1, 1'b0, 1'b0, 32'h0, 0);
        check_next_fetch("beq_target");
    endtask

    task automatic test_jump;
        for (int i = 0; i < 10 && m_pc != 32'h0000_3020; i++) begin
            retire("walk", 1'b0, 1'b0, 1'b0, 32'h0, 0);
            check_next_fetch("walk_addr");
        end
        retire("j", 1'b0, 1'b1, 1'b0, 32'h0, 0);
        mem[32'h0000_3020] = {OP_JAL, 26'h000_0C10};
        check_next_fetch("j_target");
        retire("jr_back", 1'b0, 1'b0, 1'b1, 32'h0000_3020, 0);
        check_next_fetch("jr_target");
        retire("jal", 1'b0, 1'b1, 1'b0, 32'h0, 0);
        check_next_fetch("jal_target");
    endtask

    task automatic test_priority;
        retire("prio", 1'b1, 1'b1, 1'b1, 32'h0000_3100, 0);
        check_next_fetch("prio_target");
    endtask

    task automatic test_random;
        rand_stall = 1'b1;
        for (int n = 0; n < 40; n++) begin
            lat = $urandom_range(1, 4);
            retire("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) == 0), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 2));
            check_next_fetch("rand_addr");
        end
        rand_stall = 1'b0;
        lat        = 1;
    endtask

    task automatic test_stall_and_reset;
        logic [31:0] held_addr;
        retire("istall", 1'b0, 1'b0, 1'b0, 32'h0, 5);
        stall_cnt = 4;
        check_next_fetch("mstall_first");
        held_addr = imem_addr;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (imem_req !== 1'b1 || imem_addr !== held_addr) begin
                miscompares++;
                $display("FAIL mstall_hold: req=%b addr=%h, required 1 %h", imem_req, imem_addr, held_addr);
            end
        end
        lat = 3;
        retire("pre_rst", 1'b0, 1'b0, 1'b0, 32'h0, 0);
        check_next_fetch("pre_rst_addr");
        @(negedge clk);
        vectors++;
        if (imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_req: req=%b, required 0 while waiting", imem_req);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midfetch_reset");
        rst_n     = 1'b1;
        stall_cnt = 3;
        m_pc      = 32'h0000_3000;
        @(negedge clk);
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
            miscompares++;
            $display("FAIL post_rst_req: req=%b addr=%h, required 1 %h", imem_req, imem_addr, m_pc);
        end
        retire("post_rst", 1'b0, 1'b0, 1'b0, 32'h0, 0);
        check_next_fetch("post_rst_next");
        lat = 1;
    endtask

    task automatic test_misalign;
        retire("pre_err", 1'b0, 1'b0, 1'b0, 32'h0, 0);
        check_next_fetch("pre_err_addr");
        retire("err_jr", 1'b0, 1'b0, 1'b1, 32'h0000_3102, 0);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL err_state: err=%b req=%b valid=%b, required 1 0 0",
                         fetch_err, imem_req, instr_valid);
            end
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("err_reset");
        rst_n = 1'b1;
        m_pc  = 32'h0000_3000;
        @(negedge clk);
        check_next_fetch("err_recover");
        retire("recover", 1'b0, 1'b0, 1'b0, 32'h0, 0);
    endtask

    initial begin
        mem[32'h0000_3010] = {OP_BEQ, 5'd1, 5'd2, 16'hFFFE};
        mem[32'h0000_3020] = {OP_J, 26'h000_0C10};
        mem[32'h0000_3040] = {OP_RTYPE, 5'd31, 15'd0, FUNCT_JR};
        @(negedge clk);
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_priority();
        test_random();
        test_stall_and_reset();
        test_misalign();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
